// File: rtl/round_key_issuer.sv
// Round-key issuer: captures the 9x64 key bank on a keys_ready rising edge and streams it forward
// (encrypt) or reverse (decrypt) over a valid/ready handshake. Optional macro: KEY_ISSUE_ABORT_EN.
module round_key_issuer #(
  parameter int unsigned NUM_KEYS = 9,
  parameter int unsigned KEY_W    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_KEYS*KEY_W-1:0] round_keys,
  input  logic                      keys_ready,
  input  logic                      start,
  input  logic                      decrypt,
  output logic [KEY_W-1:0]          key_out,
  output logic [3:0]                key_idx,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic                      key_last,
  output logic                      busy,
  output logic                      done,
`ifdef KEY_ISSUE_ABORT_EN
  output logic                      abort,
`endif
  output logic                      bank_valid
);

  localparam logic [3:0] LastIdx = 4'(NUM_KEYS - 1);

  typedef enum logic [1:0] {StIdle, StWaitKeys, StIssue, StDone} state_e;

  state_e                    state_q;
  logic                      kr_q;
  logic                      dir_q;
  logic [NUM_KEYS*KEY_W-1:0] bank_q;

  logic                      rise, fall, hs;
  logic                      dir_sel;
  logic [NUM_KEYS*KEY_W-1:0] src_bank;
  logic [3:0]                first_idx, next_idx;
  logic [KEY_W-1:0]          first_key, next_key;
  logic                      first_last, next_last;

  function automatic logic [KEY_W-1:0] pick(input logic [NUM_KEYS*KEY_W-1:0] b,
                                            input logic [3:0]                idx);
    logic [KEY_W-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (idx == 4'(i)) k = b[i*KEY_W +: KEY_W];
    end
    return k;
  endfunction

  assign rise = keys_ready & ~kr_q;
  assign fall = ~keys_ready & kr_q;
  assign hs   = key_valid & key_ready;

  // A capture in this cycle must already feed the key being loaded this cycle.
  assign src_bank = rise ? round_keys : bank_q;

  // In IDLE the direction comes straight from the request; afterwards from the latched copy.
  assign dir_sel    = (state_q == StIdle) ? decrypt : dir_q;
  assign first_idx  = dir_sel ? LastIdx : 4'd0;
  assign first_last = dir_sel ? (first_idx == 4'd0) : (first_idx == LastIdx);
  assign first_key  = pick(src_bank, first_idx);

  assign next_idx  = dir_q ? (key_idx - 4'd1) : (key_idx + 4'd1);
  assign next_last = dir_q ? (next_idx == 4'd0) : (next_idx == LastIdx);
  assign next_key  = pick(src_bank, next_idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      kr_q       <= 1'b0;
      dir_q      <= 1'b0;
      bank_q     <= '0;
      bank_valid <= 1'b0;
      key_out    <= '0;
      key_idx    <= '0;
      key_valid  <= 1'b0;
      key_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef KEY_ISSUE_ABORT_EN
      abort      <= 1'b0;
`endif
    end else begin
      kr_q <= keys_ready;
      done <= 1'b0;
`ifdef KEY_ISSUE_ABORT_EN
      abort <= 1'b0;
`endif
      if (rise) begin
        bank_q     <= round_keys;
        bank_valid <= 1'b1;
      end else if (fall) begin
        bank_valid <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            dir_q <= decrypt;
            busy  <= 1'b1;
            if (bank_valid || rise) begin
              state_q   <= StIssue;
              key_valid <= 1'b1;
              key_idx   <= first_idx;
              key_out   <= first_key;
              key_last  <= first_last;
            end else begin
              state_q <= StWaitKeys;
            end
          end
        end
        StWaitKeys: begin
`ifdef KEY_ISSUE_ABORT_EN
          if (fall) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            abort   <= 1'b1;
          end else
`endif
          if (bank_valid) begin
            state_q   <= StIssue;
            key_valid <= 1'b1;
            key_idx   <= first_idx;
            key_out   <= first_key;
            key_last  <= first_last;
          end
        end
        StIssue: begin
`ifdef KEY_ISSUE_ABORT_EN
          if (fall || rise) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            key_last  <= 1'b0;
            abort     <= 1'b1;
          end else
`endif
          if (hs) begin
            if (key_last) begin
              state_q   <= StDone;
              key_valid <= 1'b0;
              key_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              key_idx  <= next_idx;
              key_out  <= next_key;
              key_last <= next_last;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_issuer.sv
// Self-checking bench for round_key_issuer: scoreboard of expected {idx, key, last} per stream.
`timescale 1ns/1ps
module tb_round_key_issuer;

  localparam int unsigned NK = 9;
  localparam int unsigned KW = 64;

  typedef logic [68:0] exp_t;  // {idx[3:0], key[63:0], last}

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NK*KW-1:0] round_keys;
  logic            keys_ready = 1'b0;
  logic            start = 1'b0;
  logic            decrypt = 1'b0;
  logic [KW-1:0]   key_out;
  logic [3:0]      key_idx;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            key_last;
  logic            busy;
  logic            done;
  logic            bank_valid;
`ifdef KEY_ISSUE_ABORT_EN
  logic            abort;
`endif

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  round_key_issuer #(.NUM_KEYS(NK), .KEY_W(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .round_keys (round_keys),
    .keys_ready (keys_ready),
    .start      (start),
    .decrypt    (decrypt),
    .key_out    (key_out),
    .key_idx    (key_idx),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_last   (key_last),
    .busy       (busy),
    .done       (done),
`ifdef KEY_ISSUE_ABORT_EN
    .abort      (abort),
`endif
    .bank_valid (bank_valid)
  );

  function automatic logic [63:0] kval(input int i);
    return 64'h1111111111111111 * 64'(i + 1);
  endfunction

  task automatic push_stream(input bit dec);
    int i;
    for (int n = 0; n < NK; n++) begin
      i = dec ? (NK - 1 - n) : n;
      sb.push_back({4'(i), kval(i), (n == NK - 1)});
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; keys_ready = 1'b0; start = 1'b0; decrypt = 1'b0; key_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_out, key_idx, key_valid, key_last, busy, done, bank_valid} !== 73'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {key_out, key_idx, key_valid, key_last, busy, done, bank_valid});
    else passes++;
`ifdef KEY_ISSUE_ABORT_EN
    checks++;
    if (abort !== 1'b0) $display("FAIL reset_abort: got %b want 0", abort);
    else passes++;
`endif
    rst = 1'b1;
  endtask

  task automatic test_stream(input bit dec);
    int   cyc;
    exp_t e;
    keys_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bank_valid !== 1'b1) $display("FAIL stream_bank_valid: got %b want 1", bank_valid);
    else passes++;
    start = 1'b1; decrypt = dec; key_ready = 1'b1;
    push_stream(dec);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 40) begin
      if (key_valid) begin
        e = sb.pop_front();
        checks++;
        if ({key_idx, key_out, key_last} !== e)
          $display("FAIL stream_key dec=%0d: got %h want %h", dec, {key_idx, key_out, key_last}, e);
        else passes++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 9) $display("FAIL stream_cycles dec=%0d: got %0d want 9", dec, cyc);
    else passes++;
    checks++;
    if ({done, key_valid, busy} !== 3'b101)
      $display("FAIL stream_done dec=%0d: got %b want 101", dec, {done, key_valid, busy});
    else passes++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL stream_idle dec=%0d: got %b want 00", dec, {done, busy});
    else passes++;
    sb.delete();
  endtask

  task automatic test_backpressure;
    int   cyc;
    int   hs;
    bit   pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b0;
    push_stream(1'b0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hs = 0;
    while (sb.size() > 0 && cyc < 80) begin
      key_ready = pat[cyc % 4];
      if (key_valid) begin
        // Every valid cycle must present the scoreboard head, stalled or not.
        checks++;
        if ({key_idx, key_out, key_last} !== sb[0])
          $display("FAIL bp_key cyc=%0d: got %h want %h", cyc, {key_idx, key_out, key_last}, sb[0]);
        else passes++;
        if (key_ready) begin
          void'(sb.pop_front());
          hs++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    key_ready = 1'b1;
    checks++;
    if (hs !== 9) $display("FAIL bp_handshakes: got %0d want 9", hs);
    else passes++;
    checks++;
    if (done !== 1'b1) $display("FAIL bp_done: got %b want 1", done);
    else passes++;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_start_before_keys;
    int   cyc;
    exp_t e;
    keys_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bank_valid !== 1'b0) $display("FAIL sbk_bank_drop: got %b want 0", bank_valid);
    else passes++;
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    push_stream(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, key_valid} !== 2'b10) $display("FAIL sbk_wait%0d: got %b want 10", i, {busy, key_valid});
      else passes++;
    end
    keys_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bank_valid, key_valid} !== 2'b10)
      $display("FAIL sbk_capture: got %b want 10", {bank_valid, key_valid});
    else passes++;
    @(negedge clk);
    cyc = 0;
    while (sb.size() > 0 && cyc < 40) begin
      if (key_valid) begin
        e = sb.pop_front();
        checks++;
        if ({key_idx, key_out, key_last} !== e)
          $display("FAIL sbk_key: got %h want %h", {key_idx, key_out, key_last}, e);
        else passes++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 9 || done !== 1'b1) $display("FAIL sbk_done: got cyc=%0d done=%b want 9/1", cyc, done);
    else passes++;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset_mid_stream;
    int   cyc;
    exp_t e;
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(key_valid && key_idx == 4'd4) && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if ({key_valid, key_idx} !== 5'h14) $display("FAIL rst_reach_idx4: got %h want 14", {key_valid, key_idx});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_out, key_idx, key_valid, key_last, busy, done, bank_valid} !== 73'd0)
      $display("FAIL rst_mid_outputs: got %h want 0",
               {key_out, key_idx, key_valid, key_last, busy, done, bank_valid});
    else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, bank_valid} !== 2'b01) $display("FAIL rst_recapture: got %b want 01", {done, bank_valid});
    else passes++;
    start = 1'b1;
    push_stream(1'b0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 40) begin
      if (key_valid) begin
        e = sb.pop_front();
        checks++;
        if ({key_idx, key_out, key_last} !== e)
          $display("FAIL rst_restart_key: got %h want %h", {key_idx, key_out, key_last}, e);
        else passes++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) $display("FAIL rst_restart_done: got %b want 1", done);
    else passes++;
    @(negedge clk);
    sb.delete();
  endtask

  task automatic test_keys_drop;
    int   cyc;
    int   hs;
    exp_t e;
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    push_stream(1'b0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hs = 0;
    while (sb.size() > 0 && cyc < 40) begin
      if (key_valid) begin
        e = sb.pop_front();
        hs++;
        checks++;
        if ({key_idx, key_out, key_last} !== e)
          $display("FAIL drop_key: got %h want %h", {key_idx, key_out, key_last}, e);
        else passes++;
        if (hs == 4) begin
          keys_ready = 1'b0;
`ifdef KEY_ISSUE_ABORT_EN
          break;
`endif
        end
      end
      cyc++;
      @(negedge clk);
    end
`ifdef KEY_ISSUE_ABORT_EN
    @(negedge clk);
    checks++;
    if ({abort, key_valid, busy, done} !== 4'b1000)
      $display("FAIL drop_abort: got %b want 1000", {abort, key_valid, busy, done});
    else passes++;
    @(negedge clk);
    checks++;
    if ({abort, done} !== 2'b00) $display("FAIL drop_abort_clear: got %b want 00", {abort, done});
    else passes++;
`else
    checks++;
    if (hs !== 9 || done !== 1'b1) $display("FAIL drop_complete: got hs=%0d done=%b want 9/1", hs, done);
    else passes++;
    @(negedge clk);
`endif
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < NK; i++) round_keys[i*KW +: KW] = kval(i);
    test_reset;
    test_stream(1'b0);
    test_stream(1'b1);
    test_backpressure;
    test_start_before_keys;
    test_reset_mid_stream;
    test_keys_drop;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
